// File: rtl/ram_arbiter_if.sv
// Requester-side and ram-side signals of the two-port ram arbiter.
// The slave modport faces the arbiter; the master modport faces the requesters and the ram.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_q,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output ram_addr, ram_data, ram_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_q,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port ram between two requesters.
// Zero-cycle grant, bounded burst under contention, read data one cycle after grant.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input logic         clk,
    input logic         rst_n,
    ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } owner_t;

    owner_t          r_owner;
    owner_t          w_owner_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic            r_last;
    logic            w_last_nx;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            w_rvalid0_nx;
    logic            w_rvalid1_nx;

    logic                  w_gv;
    logic                  w_g;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // grant decision: w_gv = someone granted, w_g = which requester
    always_comb begin
        w_gv = bus.req0 | bus.req1;
        w_g  = 1'b0;
        if (bus.req0 & bus.req1) begin
            case (r_owner)
                OWN_R0:  w_g = (r_cnt >= MAXC);
                OWN_R1:  w_g = (r_cnt < MAXC);
                default: w_g = ~r_last;
            endcase
        end else begin
            w_g = bus.req1;
        end
    end

    // ram mux; requester 0 fields drive the ram when idle
    always_comb begin
        w_we         = w_g ? bus.we1 : bus.we0;
        w_addr       = w_g ? bus.addr1 : bus.addr0;
        w_wdata      = w_g ? bus.wdata1 : bus.wdata0;
        bus.ram_addr = w_addr;
        bus.ram_data = w_wdata;
        bus.ram_we   = w_gv & w_we;
        bus.gnt0     = w_gv & ~w_g;
        bus.gnt1     = w_gv & w_g;
        bus.rvalid0  = r_rvalid0;
        bus.rvalid1  = r_rvalid1;
        bus.rdata0   = bus.ram_q;
        bus.rdata1   = bus.ram_q;
    end

    // next owner, burst count, tie-break history and read-valid pipeline
    always_comb begin
        w_owner_nx   = OWN_NONE;
        w_cnt_nx     = '0;
        w_last_nx    = r_last;
        w_rvalid0_nx = w_gv & ~w_g & ~w_we;
        w_rvalid1_nx = w_gv & w_g & ~w_we;
        if (w_gv) begin
            w_owner_nx = w_g ? OWN_R1 : OWN_R0;
            w_last_nx  = w_g;
            if (w_owner_nx == r_owner) begin
                w_cnt_nx = (r_cnt >= MAXC) ? MAXC : r_cnt + CW'(1);
            end else begin
                w_cnt_nx = CW'(1);
            end
        end
    end

    // state registers; last=1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_NONE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_owner   <= w_owner_nx;
            r_cnt     <= w_cnt_nx;
            r_last    <= w_last_nx;
            r_rvalid0 <= w_rvalid0_nx;
            r_rvalid1 <= w_rvalid1_nx;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic
// against a behavioural arbitration and memory model.
module tb_ram_arbiter;
    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MAXB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ram with registered read address, contents untouched by reset
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= ram[bus.ram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    int          m_owner;
    int          m_cnt;
    int          m_last;
    int          last_g;
    bit          m_pv [2];
    bit          m_pk [2];
    logic [DW-1:0] m_pd [2];
    logic [DW-1:0] mm [16];
    bit          wr [16];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(bit r0, bit r1);
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r1 ? 1 : 0;
        if (m_owner < 0) return 1 - m_last;
        if (m_cnt < MAXB) return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        for (int i = 0; i < 2; i++) m_pv[i] = 1'b0;
    endtask

    task automatic drv(int i, bit r, bit w, int a, int d);
        if (i == 0) begin
            bus.req0 = r; bus.we0 = w;
            bus.addr0 = AW'(a); bus.wdata0 = DW'(d);
        end else begin
            bus.req1 = r; bus.we1 = w;
            bus.addr1 = AW'(a); bus.wdata1 = DW'(d);
        end
    endtask

    task automatic step();
        int            g;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        g  = pick(bus.req0, bus.req1);
        we = (g == 1) ? bus.we1 : bus.we0;
        a  = (g == 1) ? bus.addr1 : bus.addr0;
        d  = (g == 1) ? bus.wdata1 : bus.wdata0;
        chk("gnt0", bus.gnt0, g == 0);
        chk("gnt1", bus.gnt1, g == 1);
        chk("ram_we", bus.ram_we, (g >= 0) && we);
        if (g >= 0) begin
            chk("ram_addr", bus.ram_addr, a);
            if (we) chk("ram_data", bus.ram_data, d);
        end
        chk("rvalid0", bus.rvalid0, m_pv[0]);
        chk("rvalid1", bus.rvalid1, m_pv[1]);
        if (m_pv[0] && m_pk[0]) chk("rdata0", bus.rdata0, m_pd[0]);
        if (m_pv[1] && m_pk[1]) chk("rdata1", bus.rdata1, m_pd[1]);
        last_g = g;
        @(posedge clk);
        for (int i = 0; i < 2; i++) m_pv[i] = 1'b0;
        if (g >= 0) begin
            m_cnt   = (g == m_owner) ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 1;
            m_owner = g;
            m_last  = g;
            if (we) begin
                mm[a[3:0]] = d;
                wr[a[3:0]] = 1'b1;
            end else begin
                m_pv[g] = 1'b1;
                m_pk[g] = wr[a[3:0]];
                m_pd[g] = mm[a[3:0]];
            end
        end else begin
            m_owner = -1;
            m_cnt   = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int a0;
        int a1;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) wr[i] = 1'b0;
        for (int i = 0; i < 2; i++) m_pk[i] = 1'b0;
        last_g = -1;
        do_reset();
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        chk("idle_gnt0", bus.gnt0, 0);
        chk("idle_ram_we", bus.ram_we, 0);

        // write A5 to 5, read it back
        drv(0, 1, 1, 5, 'hA5);
        step();
        drv(0, 1, 0, 5, 0);
        step();
        chk("t1_rvalid0", bus.rvalid0, 1);
        chk("t1_rdata0", bus.rdata0, 'hA5);
        drv(0, 0, 0, 0, 0);
        step();

        // write from 1 then read from 0 of the same address
        drv(1, 1, 1, 3, 'h3C);
        step();
        drv(1, 0, 0, 0, 0);
        drv(0, 1, 0, 3, 0);
        step();
        chk("t5_rdata0", bus.rdata0, 'h3C);
        drv(0, 0, 0, 0, 0);
        step();

        // uncontended streaming reads from requester 1
        do_reset();
        a1 = 0;
        drv(1, 1, 0, a1, 0);
        repeat (10) begin
            step();
            a1++;
            drv(1, 1, 0, a1, 0);
        end
        drv(1, 0, 0, 0, 0);
        step();

        // tie after reset, then tie from idle
        do_reset();
        drv(0, 1, 0, 1, 0);
        drv(1, 1, 0, 2, 0);
        step();
        drv(0, 0, 0, 0, 0);
        step();
        drv(1, 0, 0, 0, 0);
        step();
        drv(0, 1, 0, 5, 0);
        drv(1, 1, 0, 3, 0);
        step();
        step();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        step();

        // held contention, then reset mid-burst
        do_reset();
        a0 = 0;
        a1 = 8;
        drv(0, 1, 0, a0, 0);
        drv(1, 1, 0, a1, 0);
        repeat (14) begin
            step();
            if (last_g == 0) begin a0 = (a0 + 1) % 16; drv(0, 1, 0, a0, 0); end
            if (last_g == 1) begin a1 = (a1 + 1) % 16; drv(1, 1, 0, a1, 0); end
        end
        chk("pre_rst_rvalid", bus.rvalid0 | bus.rvalid1, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid0", bus.rvalid0, 0);
        chk("mid_rst_rvalid1", bus.rvalid1, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            step();
            if (last_g == 0) begin a0 = (a0 + 1) % 16; drv(0, 1, 0, a0, 0); end
            if (last_g == 1) begin a1 = (a1 + 1) % 16; drv(1, 1, 0, a1, 0); end
        end

        // random traffic; requests held until granted
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                bit r;
                r = (i == 0) ? bus.req0 : bus.req1;
                if (!r || last_g == i) begin
                    if ($urandom_range(0, 3) != 0)
                        drv(i, 1, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 255)));
                    else
                        drv(i, 0, 0, 0, 0);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
